// File: rtl/step_sequencer_core_if.sv
// Control, pattern-write and playback signals shared between the pattern-edit UI
// (master) and step_sequencer_core (slave).
interface step_sequencer_core_if #(
    parameter int NUM_STEPS  = 16,
    parameter int NUM_TRACKS = 2,
    parameter int NOTE_W     = 4,
    parameter int TICK_W     = 24
) ();
    localparam int SW = $clog2(NUM_STEPS);
    localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

    logic                         start;
    logic                         stop;
    logic                         pause;
    logic [TICK_W-1:0]            ticks_per_step;
    logic [TICK_W-1:0]            gate_ticks;
    logic                         wr_en;
    logic [TW-1:0]                wr_track;
    logic [SW-1:0]                wr_step;
    logic [NOTE_W-1:0]            wr_note;
    logic [SW-1:0]                step_idx;
    logic                         step_pulse;
    logic [NUM_TRACKS*NOTE_W-1:0] note_out;
    logic [NUM_TRACKS-1:0]        gate_out;
    logic                         running;

    modport master (
        output start, stop, pause, ticks_per_step, gate_ticks,
        output wr_en, wr_track, wr_step, wr_note,
        input  step_idx, step_pulse, note_out, gate_out, running
    );

    modport slave (
        input  start, stop, pause, ticks_per_step, gate_ticks,
        input  wr_en, wr_track, wr_step, wr_note,
        output step_idx, step_pulse, note_out, gate_out, running
    );
endinterface

// File: rtl/step_sequencer_core.sv
// Multi-track step sequencer: writable pattern store, IDLE/RUN/PAUSE transport,
// live tempo and gate length, registered per-track note codes and gates.
module step_sequencer_core #(
    parameter int NUM_STEPS  = 16,
    parameter int NUM_TRACKS = 2,
    parameter int NOTE_W     = 4,
    parameter int TICK_W     = 24
) (
    input logic                  clk,
    input logic                  rst_n,
    step_sequencer_core_if.slave bus
);
    localparam int SW = $clog2(NUM_STEPS);
    localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [SW-1:0]         step_q, step_d;
    logic                  pulse_q;
    logic [NUM_TRACKS-1:0] gate_q, gate_d;
    logic [NOTE_W-1:0]     note_q  [NUM_TRACKS];
    logic [NOTE_W-1:0]     note_d  [NUM_TRACKS];
    logic [NOTE_W-1:0]     store_q [NUM_TRACKS][NUM_STEPS];
    logic [TICK_W-1:0]     tps_m1;
    logic                  advance;
    logic                  enter_step;
    logic                  clear_notes;
    logic                  wr_ok;

    // A tempo of 0 behaves as 1 tick per step.
    assign tps_m1 = (bus.ticks_per_step == '0) ? '0 : bus.ticks_per_step - TICK_W'(1);
    assign wr_ok  = bus.wr_en && (32'(bus.wr_track) < NUM_TRACKS) && (32'(bus.wr_step) < NUM_STEPS);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        step_d      = step_q;
        advance     = 1'b0;
        enter_step  = 1'b0;
        clear_notes = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RUN;
                    tick_d     = '0;
                    step_d     = '0;
                    enter_step = 1'b1;
                end
            end
            RUN: begin
                if (bus.pause && !bus.start) state_d = PAUSE;
                else                         advance = 1'b1;
            end
            PAUSE: begin
                // Resuming consumes the frozen tick like any other RUN cycle.
                if (bus.start) begin
                    state_d = RUN;
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop) begin
            state_d     = IDLE;
            tick_d      = '0;
            step_d      = '0;
            advance     = 1'b0;
            enter_step  = 1'b0;
            clear_notes = 1'b1;
        end

        // >= so a live tempo decrease below the current tick advances at once.
        if (advance) begin
            if (tick_q >= tps_m1) begin
                tick_d     = '0;
                step_d     = (step_q == LAST_STEP) ? '0 : step_q + 1'b1;
                enter_step = 1'b1;
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TRACKS; t++) begin
            note_d[t] = note_q[t];
            if (clear_notes)     note_d[t] = '0;
            else if (enter_step) note_d[t] = store_q[t][step_d];
            gate_d[t] = (state_d == RUN) && (note_d[t] != '0) && (tick_d < bus.gate_ticks);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tick_q  <= '0;
            step_q  <= '0;
            pulse_q <= 1'b0;
            gate_q  <= '0;
            for (int t = 0; t < NUM_TRACKS; t++) note_q[t] <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            pulse_q <= enter_step;
            gate_q  <= gate_d;
            for (int t = 0; t < NUM_TRACKS; t++) note_q[t] <= note_d[t];
        end
    end

    // Store reads above see the pre-write value, so edits never disturb a playing step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TRACKS; t++)
                for (int s = 0; s < NUM_STEPS; s++)
                    store_q[t][s] <= '0;
        end else if (wr_ok) begin
            store_q[bus.wr_track][bus.wr_step] <= bus.wr_note;
        end
    end

    assign bus.step_idx   = step_q;
    assign bus.step_pulse = pulse_q;
    assign bus.gate_out   = gate_q;
    assign bus.running    = (state_q == RUN);

    for (genvar g = 0; g < NUM_TRACKS; g++) begin : g_note
        assign bus.note_out[g*NOTE_W +: NOTE_W] = note_q[g];
    end
endmodule

// File: tb/tb_step_sequencer_core.sv
// Bench for step_sequencer_core: directed transport scenarios plus random traffic,
// all checked every cycle against a behavioural model of the sequencer.
module tb_step_sequencer_core;
    localparam int NS  = 16;
    localparam int NT  = 3;
    localparam int NW  = 4;
    localparam int TKW = 24;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    step_sequencer_core_if #(.NUM_STEPS(NS), .NUM_TRACKS(NT), .NOTE_W(NW), .TICK_W(TKW)) bus ();

    step_sequencer_core #(.NUM_STEPS(NS), .NUM_TRACKS(NT), .NOTE_W(NW), .TICK_W(TKW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_state 0 = stopped, 1 = playing, 2 = paused.
    int              m_state = 0;
    int              m_tick  = 0;
    int              m_step  = 0;
    int              tps     = 1;
    bit              m_pulse = 1'b0;
    bit              entered = 1'b0;
    bit              adv     = 1'b0;
    logic [NW-1:0]   m_note  [NT];
    logic [NT-1:0]   m_gate  = '0;
    logic [NW-1:0]   m_store [NT][NS];
    logic [NT*NW-1:0] exp_notes;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_state = 0; m_tick = 0; m_step = 0; m_pulse = 1'b0; m_gate = '0;
            foreach (m_note[t]) m_note[t] = '0;
            foreach (m_store[t, s]) m_store[t][s] = '0;
        end else begin
            tps = (bus.ticks_per_step == 0) ? 1 : int'(bus.ticks_per_step);
            adv = 1'b0;
            entered = 1'b0;
            if (bus.stop) begin
                m_state = 0; m_tick = 0; m_step = 0;
                foreach (m_note[t]) m_note[t] = '0;
            end else if (m_state == 0) begin
                if (bus.start) begin
                    m_state = 1; m_tick = 0; m_step = 0; entered = 1'b1;
                end
            end else if (m_state == 2) begin
                if (bus.start) begin
                    m_state = 1; adv = 1'b1;
                end
            end else if (bus.pause && !bus.start) begin
                m_state = 2;
            end else begin
                adv = 1'b1;
            end
            if (adv) begin
                if (m_tick + 1 >= tps) begin
                    m_tick = 0; m_step = (m_step + 1) % NS; entered = 1'b1;
                end else begin
                    m_tick++;
                end
            end
            if (entered) foreach (m_note[t]) m_note[t] = m_store[t][m_step];
            m_pulse = entered;
            foreach (m_note[t])
                m_gate[t] = (m_state == 1) && (m_note[t] != 0) && (m_tick < int'(bus.gate_ticks));
            if (bus.wr_en && bus.wr_track < NT && bus.wr_step < NS)
                m_store[bus.wr_track][bus.wr_step] = bus.wr_note;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            foreach (m_note[t]) exp_notes[t*NW +: NW] = m_note[t];
            check("model_step_idx",   bus.step_idx,   m_step);
            check("model_step_pulse", bus.step_pulse, m_pulse);
            check("model_note_out",   bus.note_out,   exp_notes);
            check("model_gate_out",   bus.gate_out,   m_gate);
            check("model_running",    bus.running,    (m_state == 1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int t, input int s, input int n);
        bus.wr_en = 1'b1; bus.wr_track = 2'(t); bus.wr_step = 4'(s); bus.wr_note = 4'(n);
        cyc();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_step(input int target, input int budget);
        int n = 0;
        do begin
            cyc();
            n++;
        end while (!(bus.step_pulse && bus.step_idx == 4'(target)) && n < budget);
        check("wait_step_reached", (bus.step_pulse && bus.step_idx == 4'(target)), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses, g0, g1;
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.ticks_per_step = '0; bus.gate_ticks = '0;
        bus.wr_en = 0; bus.wr_track = '0; bus.wr_step = '0; bus.wr_note = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_step_idx", bus.step_idx, 0);
        check("rst_note_out", bus.note_out, 0);
        check("rst_gate_out", bus.gate_out, 0);
        check("rst_pulse",    bus.step_pulse, 0);
        check("rst_running",  bus.running, 0);

        for (int s = 0; s < NS; s++) begin
            wr(0, s, (s + 1) % 16);
            wr(1, s, (s == 3) ? 0 : (s % 15) + 1);
            wr(2, s, $urandom_range(0, 15));
        end

        // Basic playback: tps 4, gate 2.
        bus.ticks_per_step = 4; bus.gate_ticks = 2;
        bus.start = 1; cyc(); bus.start = 0;
        check("start_pulse", bus.step_pulse, 1);
        check("start_step",  bus.step_idx, 0);
        check("start_note0", bus.note_out[3:0], 1);
        check("start_gate0", bus.gate_out[0], 1);
        pulses = 0; g0 = 0;
        for (int i = 0; i < 64; i++) begin
            pulses += int'(bus.step_pulse);
            g0 += int'(bus.gate_out[0]);
            if (bus.step_pulse) check("play_note0", bus.note_out[3:0], (int'(bus.step_idx) + 1) % 16);
            cyc();
        end
        check("pattern_pulses", pulses, 16);
        check("pattern_gate0_cycles", g0, 30);
        check("pattern_wrap_step", bus.step_idx, 0);
        check("pattern_wrap_pulse", bus.step_pulse, 1);

        // Legato on track 1 with a rest at step 3.
        bus.gate_ticks = 4;
        wait_step(1, 80);
        g1 = 0;
        for (int i = 0; i < 8; i++) begin g1 += int'(bus.gate_out[1]); cyc(); end
        check("legato_gate1_steps12", g1, 8);
        g1 = 0;
        for (int i = 0; i < 4; i++) begin g1 += int'(bus.gate_out[1]); cyc(); end
        check("rest_gate1_step3", g1, 0);

        // Pause at step 6 tick 2, resume.
        bus.gate_ticks = 2;
        wait_step(6, 80);
        cyc(); cyc();
        bus.pause = 1; cyc(); bus.pause = 0;
        check("pause_running", bus.running, 0);
        for (int i = 0; i < 10; i++) begin
            check("pause_gate", bus.gate_out, 0);
            check("pause_pulse", bus.step_pulse, 0);
            cyc();
        end
        bus.start = 1; cyc(); bus.start = 0;
        check("resume_running", bus.running, 1);
        check("resume_no_pulse", bus.step_pulse, 0);
        check("resume_step", bus.step_idx, 6);
        cyc();
        check("resume_step7_pulse", bus.step_pulse, 1);
        check("resume_step7_idx", bus.step_idx, 7);
        cyc();
        check("resume_single_pulse", bus.step_pulse, 0);

        // Edit the playing step and try an out-of-range track.
        wait_step(9, 80);
        wr(0, 9, 5);
        wr(3, 10, 15);
        check("edit_playing_held", bus.note_out[3:0], 10);
        wait_step(10, 10);
        check("bad_track_ignored", bus.note_out[3:0], 11);
        wait_step(9, 80);
        check("edit_after_wrap", bus.note_out[3:0], 5);

        // Tempo 0 steps every cycle.
        bus.ticks_per_step = 0; cyc();
        pulses = 0;
        for (int i = 0; i < 8; i++) begin pulses += int'(bus.step_pulse); cyc(); end
        check("tps0_pulses", pulses, 8);

        // Live tempo decrease below the current tick.
        bus.ticks_per_step = 8;
        wait_step(3, 200);
        repeat (5) cyc();
        bus.ticks_per_step = 2; cyc();
        check("tps_drop_pulse", bus.step_pulse, 1);
        check("tps_drop_step", bus.step_idx, 4);
        cyc();
        check("tps2_gap", bus.step_pulse, 0);
        cyc();
        check("tps2_next", bus.step_pulse, 1);

        // stop wins over start.
        bus.stop = 1; bus.start = 1; cyc(); bus.stop = 0; bus.start = 0;
        check("stopstart_running", bus.running, 0);
        check("stopstart_step", bus.step_idx, 0);
        check("stopstart_notes", bus.note_out, 0);
        cyc();
        check("stopstart_idle", bus.running, 0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.start = ($urandom_range(0, 19) == 0);
            bus.stop  = ($urandom_range(0, 39) == 0);
            bus.pause = ($urandom_range(0, 29) == 0);
            if (i % 50 == 0) bus.ticks_per_step = TKW'($urandom_range(0, 5));
            bus.gate_ticks = TKW'($urandom_range(0, 6));
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_track = 2'($urandom_range(0, 3));
            bus.wr_step  = 4'($urandom_range(0, 15));
            bus.wr_note  = 4'($urandom_range(0, 15));
            cyc();
        end
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.wr_en = 0;

        // Asynchronous reset in the middle of step 5.
        bus.stop = 1; cyc(); bus.stop = 0;
        bus.ticks_per_step = 3; bus.gate_ticks = 3;
        bus.start = 1; cyc(); bus.start = 0;
        wait_step(5, 40);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_step", bus.step_idx, 0);
        check("async_rst_notes", bus.note_out, 0);
        check("async_rst_gate", bus.gate_out, 0);
        check("async_rst_pulse", bus.step_pulse, 0);
        check("async_rst_running", bus.running, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.start = 1; cyc(); bus.start = 0;
        for (int i = 0; i < 6; i++) begin
            check("cleared_store_notes", bus.note_out, 0);
            check("cleared_store_gate", bus.gate_out, 0);
            cyc();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
